// File: rtl/instr_encoder_pkg.sv
// rtl/instr_encoder_pkg.sv - shared RV32I format codes, opcodes and field assembly
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    FMT_R     = 3'd0,
    FMT_I     = 3'd1,
    FMT_SHIFT = 3'd2,
    FMT_S     = 3'd3,
    FMT_B     = 3'd4,
    FMT_U     = 3'd5,
    FMT_J     = 3'd6,
    FMT_RSV   = 3'd7
  } fmt_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef struct packed {
    fmt_e        fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } fields_t;

  // Scatters immediate bits exactly where the core's decoder gathers them;
  // out-of-range immediates simply lose their upper bits.
  function automatic logic [31:0] encode_fields(input fields_t f);
    logic [31:0] i;
    logic [31:0] w;
    i = f.imm;
    w = '0;
    case (f.fmt)
      FMT_R:     w = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
      FMT_I:     w = {i[11:0], f.rs1, f.funct3, f.rd, f.opcode};
      FMT_SHIFT: w = {f.funct7, i[4:0], f.rs1, f.funct3, f.rd, f.opcode};
      FMT_S:     w = {i[11:5], f.rs2, f.rs1, f.funct3, i[4:0], f.opcode};
      FMT_B:     w = {i[12], i[10:5], f.rs2, f.rs1, f.funct3, i[4:1], i[11], f.opcode};
      FMT_U:     w = {i[31:12], f.rd, f.opcode};
      FMT_J:     w = {i[20], i[10:1], i[11], i[19:12], f.rd, f.opcode};
      default:   w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instr_encoder_imm_range_chk.sv
// rtl/instr_encoder_imm_range_chk.sv - combinational immediate range/alignment checker
module imm_range_chk
  import instr_encoder_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [31:0] imm,
  output logic        err
);

  // A value fits a signed N-bit field when bits [31:N-1] are all equal.
  logic fits12;
  logic fits13;
  logic fits21;

  assign fits12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign fits21 = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    err = 1'b0;
    case (fmt_e'(fmt))
      FMT_R:     err = 1'b0;
      FMT_I:     err = ~fits12;
      FMT_SHIFT: err = |imm[31:5];
      FMT_S:     err = ~fits12;
      FMT_B:     err = ~fits13 | imm[0];
      FMT_U:     err = |imm[11:0];
      FMT_J:     err = ~fits21 | imm[0];
      default:   err = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - two-stage RV32I instruction encoder with ready/valid handshakes
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic [31:0] count
);

  fields_t     in_fields;
  logic        in_err;

  logic        s1_valid_q, s1_valid_d;
  fields_t     s1_f_q, s1_f_d;
  logic        s1_err_q, s1_err_d;
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] s2_instr_q, s2_instr_d;
  logic        s2_err_q, s2_err_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] count_q, count_d;

  logic        s2_free;
  logic        s1_adv;
  logic        in_fire;
  logic        out_fire;

  always_comb begin
    in_fields.fmt    = fmt_e'(fmt);
    in_fields.opcode = opcode;
    in_fields.rd     = rd;
    in_fields.rs1    = rs1;
    in_fields.rs2    = rs2;
    in_fields.funct3 = funct3;
    in_fields.funct7 = funct7;
    in_fields.imm    = imm;
  end

  imm_range_chk u_range_chk (
    .fmt (fmt),
    .imm (imm),
    .err (in_err)
  );

  // S2 frees up either because it is empty or because its word leaves this cycle.
  assign s2_free  = !s2_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_free;
  assign in_ready = !s1_valid_q || s1_adv;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = s2_valid_q && out_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_f_d     = s1_f_q;
    s1_err_d   = s1_err_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_f_d     = in_fields;
      s1_err_d   = in_err;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // The S2 word register is only rewritten on advance, so a stalled word holds.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_instr_d = s2_instr_q;
    s2_err_d   = s2_err_q;
    if (s1_adv) begin
      s2_valid_d = 1'b1;
      s2_instr_d = encode_fields(s1_f_q);
      s2_err_d   = s1_err_q;
    end else if (out_fire) begin
      s2_valid_d = 1'b0;
    end
  end

  always_comb begin
    addr_d  = addr_q;
    count_d = count_q;
    if (out_fire) begin
      addr_d  = addr_q + 32'd4;
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      s1_valid_q <= 1'b0;
      s1_f_q     <= '0;
      s1_err_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_instr_q <= '0;
      s2_err_q   <= 1'b0;
      addr_q     <= BASE_ADDR;
      count_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_f_q     <= s1_f_d;
      s1_err_q   <= s1_err_d;
      s2_valid_q <= s2_valid_d;
      s2_instr_q <= s2_instr_d;
      s2_err_q   <= s2_err_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_instr = s2_instr_q;
  assign out_err   = s2_err_q;
  assign out_addr  = addr_q;
  assign count     = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - randomized and directed bench for instr_encoder
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  fmt = '0;
  logic [6:0]  opcode = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [31:0] imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;
  logic [31:0] count;

  instr_encoder #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .out_err(out_err), .count(count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] w;
    logic        e;
    logic [2:0]  f;
    logic [31:0] imm;
  } exp_t;

  exp_t        q[$];
  logic [31:0] exp_count = 0;

  // Reference encoding built from field positions and value ranges.
  function automatic void model(input logic [2:0] f, input logic [6:0] op,
                                input logic [4:0] rd_, input logic [4:0] rs1_,
                                input logic [4:0] rs2_, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] im,
                                output logic [31:0] w, output logic e);
    int v;
    logic [31:0] o, d, r1, r2, t3, t7;
    v  = $signed(im);
    o  = 32'(op);
    d  = 32'(rd_) << 7;
    r1 = 32'(rs1_) << 15;
    r2 = 32'(rs2_) << 20;
    t3 = 32'(f3) << 12;
    t7 = 32'(f7) << 25;
    case (f)
      3'd0: begin w = t7 | r2 | r1 | t3 | d | o; e = 1'b0; end
      3'd1: begin w = ((im & 32'hFFF) << 20) | r1 | t3 | d | o; e = (v < -2048) || (v > 2047); end
      3'd2: begin w = t7 | ((im & 32'd31) << 20) | r1 | t3 | d | o; e = (im >> 5) != 0; end
      3'd3: begin
        w = (((im >> 5) & 32'h7F) << 25) | r2 | r1 | t3 | ((im & 32'd31) << 7) | o;
        e = (v < -2048) || (v > 2047);
      end
      3'd4: begin
        w = (((im >> 12) & 32'd1) << 31) | (((im >> 5) & 32'h3F) << 25) | r2 | r1 | t3 |
            (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'd1) << 7) | o;
        e = (v < -4096) || (v > 4094) || ((im & 32'd1) != 0);
      end
      3'd5: begin w = (im & 32'hFFFFF000) | d | o; e = (im & 32'hFFF) != 0; end
      3'd6: begin
        w = (((im >> 20) & 32'd1) << 31) | (((im >> 1) & 32'h3FF) << 21) |
            (((im >> 11) & 32'd1) << 20) | (im & 32'h000FF000) | d | o;
        e = (v < -1048576) || (v > 1048574) || ((im & 32'd1) != 0);
      end
      default: begin w = 32'h0; e = 1'b1; end
    endcase
  endfunction

  // Independent decoder: what the core would recover from the word.
  function automatic logic [31:0] decode_imm(input logic [2:0] f, input logic [31:0] w);
    logic signed [11:0] t12;
    logic signed [12:0] t13;
    logic signed [20:0] t21;
    logic [31:0] r;
    r = 32'h0;
    case (f)
      3'd1: begin t12 = w[31:20]; r = 32'(t12); end
      3'd2: r = 32'(w[24:20]);
      3'd3: begin t12 = {w[31:25], w[11:7]}; r = 32'(t12); end
      3'd4: begin t13 = {w[31], w[7], w[30:25], w[11:8], 1'b0}; r = 32'(t13); end
      3'd5: r = {w[31:12], 12'h0};
      3'd6: begin t21 = {w[31], w[19:12], w[20], w[30:21], 1'b0}; r = 32'(t21); end
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  logic        stalled = 1'b0;
  logic [31:0] prev_instr, prev_addr;
  logic        prev_err;

  always @(negedge clk) begin
    if (Reset) begin
      q.delete();
      exp_count = 0;
      stalled = 1'b0;
    end else begin
      chk("count", count, exp_count);
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 32'(out_valid), 32'd0);
        end else begin
          chk("out_instr", out_instr, q[0].w);
          chk("out_err", 32'(out_err), 32'(q[0].e));
          chk("out_addr", out_addr, BASE + 32'd4 * exp_count);
          if (!q[0].e && q[0].f != 3'd0)
            chk("roundtrip_imm", decode_imm(q[0].f, out_instr), q[0].imm);
          if (stalled) begin
            chk("stall_instr", out_instr, prev_instr);
            chk("stall_addr", out_addr, prev_addr);
            chk("stall_err", 32'(out_err), 32'(prev_err));
          end
          if (out_ready) begin
            void'(q.pop_front());
            exp_count = exp_count + 1;
          end
        end
      end
      stalled    = out_valid && !out_ready;
      prev_instr = out_instr;
      prev_addr  = out_addr;
      prev_err   = out_err;
      if (in_valid && in_ready) begin
        exp_t it;
        model(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, it.w, it.e);
        it.f   = fmt;
        it.imm = imm;
        q.push_back(it);
      end
    end
  end

  int n_acc = 0;
  int stall_acc = -1;

  task automatic set_fields(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                            input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] im);
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
  endtask

  // Holds in_valid until the word is taken; called just after a rising edge.
  task automatic push_word();
    bit done;
    done = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1;
        n_acc++;
      end else if (stall_acc < 0) begin
        stall_acc = n_acc;
      end
      @(posedge clk); #1;
    end
    if (!done) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    Reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    Reset = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", count, 32'd0);
    chk("rst_out_addr", out_addr, BASE);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic directed(input string name, input logic [2:0] f, input logic [6:0] op,
                          input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                          input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im,
                          input logic [31:0] exp_w, input logic exp_e, input bit check_addr);
    out_ready = 1'b1;
    @(posedge clk); #1;
    set_fields(f, op, d, s1, s2, f3, f7, im);
    in_valid = 1'b1;
    @(negedge clk);
    chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({name, "_early_valid"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_instr"}, out_instr, exp_w);
    chk({name, "_err"}, 32'(out_err), 32'(exp_e));
    if (check_addr) chk({name, "_addr"}, out_addr, BASE);
  endtask

  task automatic set_rand();
    int bnd[14] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098,
                    1048574, 1048576, -1048576, -1048578, 31, 32};
    logic [31:0] im;
    set_fields(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
               5'($urandom), 3'($urandom), 7'($urandom), 32'h0);
    case ($urandom_range(0, 5))
      0: im = $urandom;
      1: im = 32'($urandom_range(0, 8191)) - 32'd4096;
      2: im = 32'(bnd[$urandom_range(0, 13)]);
      3: im = ($urandom & 32'h001FFFFE) - 32'h00100000;
      4: im = $urandom & 32'hFFFFF000;
      default: im = 32'($urandom_range(0, 40));
    endcase
    imm = im;
  endtask

  bit rnd_done;

  initial begin
    repeat (2) @(posedge clk);
    do_reset();

    directed("addi", 3'd1, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b0, 1'b1);
    directed("sw", 3'd3, OP_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0020A423, 1'b0, 1'b0);
    directed("beq", 3'd4, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4, 32'hFE000EE3, 1'b0, 1'b0);
    directed("jal", 3'd6, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h001000EF, 1'b0, 1'b0);
    directed("lui", 3'd5, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b0, 1'b0);
    directed("add", 3'd0, OP_REG, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEADBEEF, 32'h002081B3, 1'b0, 1'b0);
    directed("slli", 3'd2, OP_IMM, 5'd1, 5'd1, 5'd0, 3'd1, 7'd0, 32'd3, 32'h00309093, 1'b0, 1'b0);
    directed("i_err", 3'd1, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h80000093, 1'b1, 1'b0);
    directed("b_err", 3'd4, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h00000163, 1'b1, 1'b0);
    directed("rsv", 3'd7, OP_IMM, 5'd7, 5'd7, 5'd7, 3'd7, 7'h7F, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0);
    @(posedge clk); #1;

    // Backpressure: four words against a stalled consumer.
    do_reset();
    stall_acc = -1;
    n_acc = 0;
    out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          set_fields(3'd1, OP_IMM, 5'(k + 1), 5'd2, 5'd0, 3'd0, 7'd0, 32'(k * 16));
          push_word();
        end
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 20 && !out_valid; c++) @(negedge clk);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    chk("bp_stall_after", 32'(stall_acc), 32'd2);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("bp_count", count, 32'd4);
    chk("bp_drained", 32'(q.size()), 32'd0);

    // Reset with two words in flight.
    @(posedge clk); #1;
    out_ready = 1'b0;
    set_fields(3'd5, OP_LUI, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001000);
    push_word();
    push_word();
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_out_valid", 32'(out_valid), 32'd1);
    do_reset();
    @(negedge clk);
    chk("mid_after_valid", 32'(out_valid), 32'd0);
    directed("post_rst", 3'd1, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b0, 1'b1);

    // Random stream with random consumer stalls.
    rnd_done = 0;
    @(posedge clk); #1;
    fork
      begin
        for (int k = 0; k < 400; k++) begin
          set_rand();
          push_word();
        end
        in_valid = 1'b0;
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 9) < 7);
        end
      end
    join
    out_ready = 1'b1;
    for (int c = 0; c < 50 && q.size() != 0; c++) @(posedge clk);
    @(negedge clk);
    chk("rand_drained", 32'(q.size()), 32'd0);
    chk("rand_out_valid", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be synchronous and active-high.
REQ-002 Parameter: BASE_ADDR, 32'h0000_0000, word-aligned address assigned to the first encoded instruction.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 Reset  in  1  synchronous active-high reset.
REQ-005 in_valid  in  1  field bundle valid.
REQ-006 in_ready  out  1  block accepts the bundle this cycle.
REQ-007 fmt  in  3  format select: 0=R, 1=I, 2=SHIFT, 3=S, 4=B, 5=U, 6=J, 7=reserved.
REQ-008 opcode  in  7; rd, rs1, rs2  in  5 each; funct3  in  3; funct7  in  7  instruction fields.
REQ-009 imm  in  32  signed byte-offset/immediate value (unencoded).
REQ-010 out_valid  out  1  encoded word valid.
REQ-011 out_ready  in  1  consumer accepts the word.
REQ-012 out_instr  out  32  encoded RV32I instruction word.
REQ-013 out_addr  out  32  address of out_instr.
REQ-014 out_err  out  1  immediate out of range, misaligned, or reserved fmt for this word.
REQ-015 count  out  32  number of words handed off since reset.

Function
REQ-016 Encoding SHALL be the exact inverse of the core's immediate decoder: decoding out_instr SHALL yield imm whenever out_err=0.
REQ-017 Common fields: [6:0]=opcode; rd in [11:7] for R/I/SHIFT/U/J; funct3 in [14:12] and rs1 in [19:15] for R/I/SHIFT/S/B; rs2 in [24:20] for R/S/B.
REQ-018 R: [31:25]=funct7; imm ignored; out_err=0.
REQ-019 I: [31:20]=imm[11:0]; error if imm outside -2048..2047.
REQ-020 SHIFT: [31:25]=funct7, [24:20]=imm[4:0]; error if imm[31:5]!=0.
REQ-021 S: [31:25]=imm[11:5], [11:7]=imm[4:0]; range as I.
REQ-022 B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]; error if imm outside -4096..4094 or imm[0]=1.
REQ-023 U: [31:12]=imm[31:12]; error if imm[11:0]!=0.
REQ-024 J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]; error if imm outside -1048576..1048574 or imm[0]=1.
REQ-025 fmt=7: out_instr=0, out_err=1.
REQ-026 On error the word SHALL still be emitted, built from the truncated bits per REQ-018..024.
REQ-027 Pipeline: two register stages (S1 capture + range check, S2 assemble); latency in-handshake to out_valid = 2 cycles when unstalled; throughput 1 word/cycle.
REQ-028 Each stage SHALL advance when its downstream stage is empty or is being emptied this cycle; in_ready = !S1_valid || S1 advancing.
REQ-029 While out_valid=1 and out_ready=0, out_instr, out_addr and out_err SHALL hold stable; no bundle SHALL be lost or duplicated.
REQ-030 out_addr SHALL equal BASE_ADDR for the first word and increase by 4 after each output handshake, wrapping modulo 2^32.
REQ-031 count SHALL increment by 1 on each output handshake, wrapping modulo 2^32.
REQ-032 Input and output handshakes in the same cycle SHALL both take effect.

Reset
REQ-033 With Reset=1 at a clock edge: S1/S2 valid cleared, out_valid=0, out_instr=0, out_err=0, out_addr=BASE_ADDR, count=0; in_ready=1 from the first cycle after reset.
REQ-034 Reset mid-operation SHALL discard in-flight words without any handshake.

Structure
REQ-035 Format codes and RV32I opcode constants SHALL live in the shared CPU constants include/package used by the decoder.
REQ-036 The combinational range checker SHALL be one sub-module, imm_range_chk (fmt, imm -> err).

Verification
REQ-037 I: opcode=0010011, rd=1, rs1=0, f3=0, imm=5 -> out_instr=0x00500093, err=0, out_addr=BASE_ADDR, 2 cycles after acceptance.
REQ-038 S/B: sw (op 0100011, f3=010, rs1=1, rs2=2, imm=8) -> 0x0020A423; beq x0,x0 (op 1100011, imm=-4) -> 0xFE000EE3.
REQ-039 J/U: jal (rd=1, imm=2048) -> 0x001000EF; lui (rd=5, imm=0x12345000) -> 0x123452B7.
REQ-040 Errors: I with imm=2048 -> err=1; B with imm=3 -> err=1; fmt=7 -> 0x00000000, err=1.
REQ-041 Backpressure: stream 4 words, out_ready=0 for 3 cycles -> in_ready falls after 2 accepted, outputs stable, order preserved, addresses +0/+4/+8/+12, count=4.
REQ-042 Reset with 2 words in flight -> out_valid=0, count=0, next word at BASE_ADDR.
